reg_load_arbiter: RTL and testbench

- Shares one 18-bit load-enabled data register between NREQ independent requesters.
- Each requester presents a write word under a req/ack handshake. A round-robin FSM selects one requester at a time and drives the register's ld/data_in pair for exactly one cycle per granted write.
- Sits between the datapath producers and the shared register.
- Also provides a write counter for the sequencing logic.

---
 rtl/reg_load_arbiter.sv | 98 +++++++++
 tb/tb_reg_load_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter sharing one load-enabled register between NREQ requesters.
// Latency: ld/ack rise 1 cycle after req is sampled in IDLE; at most one write every 2 cycles.
// Backpressure: requesters hold req/wdata until ack; losers simply wait for their turn.
module reg_load_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       ack,
    output logic                  ld,
    output logic [WIDTH-1:0]      data_in,
    output logic [1:0]            grant_id,
    output logic                  busy,
    output logic [15:0]           wr_count
);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t            state, state_nxt;
    logic [1:0]        rr_ptr, rr_ptr_nxt;
    logic [1:0]        winner, idx;
    logic              found;
    logic [NREQ-1:0]   ack_nxt;
    logic              ld_nxt, busy_nxt;
    logic [WIDTH-1:0]  data_nxt;
    logic [1:0]        grant_nxt;
    logic [15:0]       count_nxt;

    // First requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        idx    = 2'd0;
        for (int k = 0; k < NREQ; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        ld_nxt     = 1'b0;
        ack_nxt    = '0;
        busy_nxt   = 1'b0;
        data_nxt   = data_in;
        grant_nxt  = grant_id;
        rr_ptr_nxt = rr_ptr;
        count_nxt  = wr_count;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = LOAD;
                    ld_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                    ack_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << winner;
                    data_nxt  = wdata[int'(winner)*WIDTH +: WIDTH];
                    grant_nxt = winner;
                end
            end
            LOAD: begin
                state_nxt  = IDLE;
                rr_ptr_nxt = grant_id + 2'd1;
                count_nxt  = wr_count + 16'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Every output is a flop; a write caught in LOAD by reset is simply dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            rr_ptr   <= 2'd0;
            ld       <= 1'b0;
            ack      <= '0;
            busy     <= 1'b0;
            data_in  <= '0;
            grant_id <= 2'd0;
            wr_count <= 16'd0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            ld       <= ld_nxt;
            ack      <= ack_nxt;
            busy     <= busy_nxt;
            data_in  <= data_nxt;
            grant_id <= grant_nxt;
            wr_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Directed bench for reg_load_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_reg_load_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = 4'b0;
    logic [71:0] wdata = '0;
    logic [3:0]  ack;
    logic        ld;
    logic [17:0] data_in;
    logic [1:0]  grant_id;
    logic        busy;
    logic [15:0] wr_count;

    int compared = 0;
    int mismatched = 0;

    reg_load_arbiter #(.NREQ(4), .WIDTH(18)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .wdata    (wdata),
        .ack      (ack),
        .ld       (ld),
        .data_in  (data_in),
        .grant_id (grant_id),
        .busy     (busy),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b0;
        req = 4'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        req   = 4'b1111;
        wdata = {18'h00004, 18'h00003, 18'h00002, 18'h00001};
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            compared++;
            if ({ld, ack, busy, grant_id, data_in, wr_count} !== {1'b0, 4'b0, 1'b0, 2'd0, 18'h0, 16'd0}) begin
                $display("FAIL reset_hold cyc%0d: got ld=%b ack=%b busy=%b gid=%0d data=%h cnt=%0d, expected all zero",
                         c, ld, ack, busy, grant_id, data_in, wr_count);
                mismatched++;
            end
        end
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if ({ld, ack, grant_id, busy, data_in} !== {1'b1, 4'b0001, 2'd0, 1'b1, 18'h00001}) begin
            $display("FAIL reset_first_grant: got ld=%b ack=%b gid=%0d busy=%b data=%h, expected 1 0001 0 1 00001",
                     ld, ack, grant_id, busy, data_in);
            mismatched++;
        end
        do_reset();
    endtask

    task automatic test_single();
        wdata = '0;
        wdata[36 +: 18] = 18'h2A5A5;
        req = 4'b0100;
        @(negedge clk);
        compared++;
        if ({ld, ack, grant_id, busy, data_in} !== {1'b1, 4'b0100, 2'd2, 1'b1, 18'h2A5A5}) begin
            $display("FAIL single_grant: got ld=%b ack=%b gid=%0d busy=%b data=%h, expected 1 0100 2 1 2a5a5",
                     ld, ack, grant_id, busy, data_in);
            mismatched++;
        end
        req = 4'b0;
        @(negedge clk);
        compared++;
        if ({ld, ack, busy, wr_count} !== {1'b0, 4'b0, 1'b0, 16'd1}) begin
            $display("FAIL single_done: got ld=%b ack=%b busy=%b cnt=%0d, expected 0 0000 0 1",
                     ld, ack, busy, wr_count);
            mismatched++;
        end
        compared++;
        if (dut.rr_ptr !== 2'd3) begin
            $display("FAIL single_rr_ptr: got %0d expected 3", dut.rr_ptr);
            mismatched++;
        end
        compared++;
        if (data_in !== 18'h2A5A5) begin
            $display("FAIL single_data_hold: got %h expected 2a5a5", data_in);
            mismatched++;
        end
    endtask

    task automatic test_pointer_wrap();
        wdata = '0;
        wdata[0 +: 18]  = 18'h11111;
        wdata[54 +: 18] = 18'h3CCCC;
        req = 4'b1001;
        @(negedge clk);
        compared++;
        if ({ld, ack, grant_id, data_in} !== {1'b1, 4'b1000, 2'd3, 18'h3CCCC}) begin
            $display("FAIL wrap_grant3: got ld=%b ack=%b gid=%0d data=%h, expected 1 1000 3 3cccc",
                     ld, ack, grant_id, data_in);
            mismatched++;
        end
        req = 4'b0001;
        @(negedge clk);
        compared++;
        if ({ld, busy} !== 2'b00) begin
            $display("FAIL wrap_gap: got ld=%b busy=%b expected 0 0", ld, busy);
            mismatched++;
        end
        @(negedge clk);
        compared++;
        if ({ld, ack, grant_id, data_in} !== {1'b1, 4'b0001, 2'd0, 18'h11111}) begin
            $display("FAIL wrap_grant0: got ld=%b ack=%b gid=%0d data=%h, expected 1 0001 0 11111",
                     ld, ack, grant_id, data_in);
            mismatched++;
        end
        req = 4'b0;
        @(negedge clk);
        compared++;
        if ({ld, wr_count, dut.rr_ptr} !== {1'b0, 16'd3, 2'd1}) begin
            $display("FAIL wrap_end: got ld=%b cnt=%0d rr=%0d expected 0 3 1", ld, wr_count, dut.rr_ptr);
            mismatched++;
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_ack;
        do_reset();
        wdata = {18'h00004, 18'h00003, 18'h00002, 18'h00001};
        req   = 4'b1111;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c % 2 == 1) begin
                exp_ack = 4'b0001 << ((c - 1) / 2);
                compared++;
                if ({ld, ack, grant_id, data_in} !== {1'b1, exp_ack, 2'((c - 1) / 2), 18'((c + 1) / 2)}) begin
                    $display("FAIL rr_grant cyc%0d: got ld=%b ack=%b gid=%0d data=%h, expected 1 %b %0d %h",
                             c, ld, ack, grant_id, data_in, exp_ack, (c - 1) / 2, (c + 1) / 2);
                    mismatched++;
                end
                req = req & ~exp_ack;
            end else begin
                compared++;
                if ({ld, ack} !== 5'b0) begin
                    $display("FAIL rr_gap cyc%0d: got ld=%b ack=%b expected 0 0000", c, ld, ack);
                    mismatched++;
                end
            end
        end
        compared++;
        if (wr_count !== 16'd4) begin
            $display("FAIL rr_count: got %0d expected 4", wr_count);
            mismatched++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wdata = '0;
        wdata[18 +: 18] = 18'h15555;
        req = 4'b0010;
        @(negedge clk);
        compared++;
        if ({ld, busy} !== 2'b11) begin
            $display("FAIL mid_in_load: got ld=%b busy=%b expected 1 1", ld, busy);
            mismatched++;
        end
        rst = 1'b0;
        req = 4'b0;
        @(negedge clk);
        compared++;
        if ({ld, ack, busy, grant_id, data_in, wr_count} !== {1'b0, 4'b0, 1'b0, 2'd0, 18'h0, 16'd0}) begin
            $display("FAIL mid_reset: got ld=%b ack=%b busy=%b gid=%0d data=%h cnt=%0d, expected all zero",
                     ld, ack, busy, grant_id, data_in, wr_count);
            mismatched++;
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if ({ld, ack, wr_count} !== {1'b0, 4'b0, 16'd0}) begin
            $display("FAIL mid_aborted: got ld=%b ack=%b cnt=%0d expected 0 0000 0", ld, ack, wr_count);
            mismatched++;
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        force dut.wr_count = 16'hFFFF;
        #1;
        release dut.wr_count;
        @(negedge clk);
        compared++;
        if (wr_count !== 16'hFFFF) begin
            $display("FAIL wrap_preload: got %h expected ffff", wr_count);
            mismatched++;
        end
        wdata = '0;
        wdata[0 +: 18] = 18'h3FFFF;
        req = 4'b0001;
        @(negedge clk);
        compared++;
        if ({ld, data_in, wr_count} !== {1'b1, 18'h3FFFF, 16'hFFFF}) begin
            $display("FAIL wrap_load: got ld=%b data=%h cnt=%h expected 1 3ffff ffff", ld, data_in, wr_count);
            mismatched++;
        end
        req = 4'b0;
        @(negedge clk);
        compared++;
        if ({ld, wr_count} !== {1'b0, 16'h0000}) begin
            $display("FAIL wrap_count: got ld=%b cnt=%h expected 0 0000", ld, wr_count);
            mismatched++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_pointer_wrap();
        test_round_robin();
        test_reset_mid();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
